// File: rtl/usb_tx_framer_pkg.sv
// usb_tx_framer_pkg: shared FMCW widths, frame marker bytes and FSM encoding.
// Host tools and the bench decode frames with these same constants.
package usb_tx_framer_pkg;

    localparam int unsigned FMCW_USBDW     = 8;
    localparam int unsigned FMCW_DW        = 12;
    localparam int unsigned FMCW_FRAME_LEN = 64;
    localparam int unsigned FMCW_FIFO_AW   = 7;

    localparam logic [7:0] USB_SYNC0 = 8'hA5;
    localparam logic [7:0] USB_SYNC1 = 8'h5A;
    localparam logic [7:0] USB_FILL  = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_CNT  = 3'd3,
        ST_DATA = 3'd4
`ifdef USB_TX_CHECKSUM_EN
        , ST_CSUM = 3'd5
`endif
    } tx_state_e;

endpackage

// File: rtl/usb_tx_fifo.sv
// usb_tx_fifo: synchronous first-word-fall-through sample FIFO.
// Exposes the head and the entry behind it so the framer never stalls.
import usb_tx_framer_pkg::*;

module usb_tx_fifo #(
    parameter int unsigned DW = FMCW_DW,
    parameter int unsigned AW = FMCW_FIFO_AW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic [DW-1:0] next_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rd_nx;
    logic [AW:0]   cnt_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rd_nx   = rd_q + 1'b1;
    assign head_o  = mem_q[rd_q];
    assign next_o  = mem_q[rd_nx];

    // A pop frees the slot a same-cycle push lands in
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_q <= rd_nx;
            end
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/usb_tx_framer.sv
// usb_tx_framer: packs buffered DSP samples into A5 5A CNT DATA.. byte frames.
// Define USB_TX_CHECKSUM_EN to append a mod-256 checksum byte to each frame.
import usb_tx_framer_pkg::*;

module usb_tx_framer #(
    parameter int unsigned      USBDW     = FMCW_USBDW,
    parameter int unsigned      DW        = FMCW_DW,
    parameter int unsigned      FRAME_LEN = FMCW_FRAME_LEN,
    parameter int unsigned      FIFO_AW   = FMCW_FIFO_AW,
    parameter logic [USBDW-1:0] SYNC0     = USBDW'(USB_SYNC0),
    parameter logic [USBDW-1:0] SYNC1     = USBDW'(USB_SYNC1),
    parameter logic [USBDW-1:0] FILL      = USBDW'(USB_FILL)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DW-1:0]    data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             overflow_o,
    input  logic             txe_n_i,
    input  logic             wr_n_i,
    output logic [USBDW-1:0] wdata_o,
    output logic [7:0]       frame_cnt_o
);

    localparam int unsigned SB  = (DW + USBDW - 1) / USBDW;
    localparam int unsigned BIW = (SB > 1) ? $clog2(SB) : 1;
    localparam int unsigned SIW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned CW  = FIFO_AW + 1;

    if (2 ** FIFO_AW < FRAME_LEN) begin : g_depth_chk
        $error("usb_tx_framer: FIFO depth smaller than FRAME_LEN");
    end

    tx_state_e        state_q;
    logic [USBDW-1:0] wdata_q;
    logic [7:0]       frame_cnt_q;
    logic             overflow_q;
    logic [BIW-1:0]   byte_q;
    logic [SIW-1:0]   samp_q;

    logic [DW-1:0]    head;
    logic [DW-1:0]    next;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             consume;
    logic             last_byte;
    logic             last_samp;
    logic             pop;
    logic             push;
    logic             ready;

`ifdef USB_TX_CHECKSUM_EN
    logic [7:0]       csum_q;
    logic [7:0]       csum_d;

    assign csum_d = csum_q + wdata_q[7:0];
`endif

    // Zero-extend to SB bytes, byte 0 is the most significant
    function automatic logic [USBDW-1:0] sample_byte(
        input logic [DW-1:0]  s,
        input logic [BIW-1:0] k
    );
        logic [SB*USBDW-1:0] ext;
        ext = '0;
        ext[DW-1:0] = s;
        return ext[(SB - 1 - int'(k)) * USBDW +: USBDW];
    endfunction

    assign consume   = !txe_n_i && !wr_n_i;
    assign last_byte = (byte_q == BIW'(SB - 1));
    assign last_samp = (samp_q == SIW'(FRAME_LEN - 1));
    assign pop       = consume && (state_q == ST_DATA) && last_byte && !empty;
    assign ready     = !full || pop;
    assign push      = valid_i && ready;

    usb_tx_fifo #(
        .DW (DW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (data_i),
        .pop_i   (pop),
        .head_o  (head),
        .next_o  (next),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            wdata_q     <= FILL;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
            byte_q      <= '0;
            samp_q      <= '0;
`ifdef USB_TX_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            if (valid_i && !ready) begin
                overflow_q <= 1'b1;
            end
            if (consume) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (count >= CW'(FRAME_LEN)) begin
                            wdata_q <= SYNC0;
                            state_q <= ST_HDR0;
`ifdef USB_TX_CHECKSUM_EN
                            csum_q  <= '0;
`endif
                        end
                    end
                    ST_HDR0: begin
                        wdata_q <= SYNC1;
                        state_q <= ST_HDR1;
                    end
                    ST_HDR1: begin
                        wdata_q <= USBDW'(frame_cnt_q);
                        state_q <= ST_CNT;
                    end
                    ST_CNT: begin
                        wdata_q <= sample_byte(head, '0);
                        byte_q  <= '0;
                        samp_q  <= '0;
                        state_q <= ST_DATA;
`ifdef USB_TX_CHECKSUM_EN
                        csum_q  <= csum_d;
`endif
                    end
                    ST_DATA: begin
`ifdef USB_TX_CHECKSUM_EN
                        csum_q <= csum_d;
`endif
                        if (!last_byte) begin
                            byte_q  <= byte_q + 1'b1;
                            wdata_q <= sample_byte(head, byte_q + 1'b1);
                        end else if (!last_samp) begin
                            byte_q  <= '0;
                            samp_q  <= samp_q + 1'b1;
                            wdata_q <= sample_byte(next, '0);
                        end else begin
                            byte_q  <= '0;
                            samp_q  <= '0;
`ifdef USB_TX_CHECKSUM_EN
                            wdata_q <= USBDW'(csum_d);
                            state_q <= ST_CSUM;
`else
                            wdata_q     <= FILL;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                            state_q     <= ST_IDLE;
`endif
                        end
                    end
`ifdef USB_TX_CHECKSUM_EN
                    ST_CSUM: begin
                        wdata_q     <= FILL;
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        state_q     <= ST_IDLE;
                    end
`endif
                    default: begin
                        wdata_q <= FILL;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign ready_o     = ready;
    assign overflow_o  = overflow_q;
    assign wdata_o     = wdata_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_usb_tx_framer.sv
// tb_usb_tx_framer: byte-stream scoreboard plus directed vectors for usb_tx_framer.
// Define USB_TX_CHECKSUM_EN for both bench and RTL to cover the checksum build.
module tb_usb_tx_framer;
    import usb_tx_framer_pkg::*;

    localparam int FL    = 64;
    localparam int DEPTH = 128;
`ifdef USB_TX_CHECKSUM_EN
    localparam int FBYTES = 3 + 2 * FL + 1;
`else
    localparam int FBYTES = 3 + 2 * FL;
`endif

    logic        clk_i   = 1'b0;
    logic        rst_i   = 1'b1;
    logic [11:0] data_i  = '0;
    logic        valid_i = 1'b0;
    logic        txe_n_i = 1'b1;
    logic        wr_n_i  = 1'b1;
    logic        ready_o;
    logic        overflow_o;
    logic [7:0]  wdata_o;
    logic [7:0]  frame_cnt_o;

    usb_tx_framer dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .overflow_o  (overflow_o),
        .txe_n_i     (txe_n_i),
        .wr_n_i      (wr_n_i),
        .wdata_o     (wdata_o),
        .frame_cnt_o (frame_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] b;
        bit         p;
    } ent_t;

    typedef struct {
        bit         txe_n;
        bit         wr_n;
        logic [7:0] wd;
        logic [7:0] fcx;
        bit         rdy;
    } vec_t;

    logic [11:0] mq[$];
    ent_t        pend[$];
    logic [7:0]  got[$];
    logic [7:0]  cur;
    logic [7:0]  fc;
    bit          cur_p;
    bit          in_frame;
    bit          m_ovf;
    bit          logging;
    int          n_vec;
    int          n_err;
    vec_t        tbl[6];
    int          k;
    int          sent;
    int          frames;
    logic [7:0]  prev_fc;
    logic [7:0]  fc0;
    logic [7:0]  hdr[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pend.delete();
        cur      = USB_FILL;
        cur_p    = 1'b0;
        in_frame = 1'b0;
        m_ovf    = 1'b0;
        fc       = 8'd0;
    endtask

    task automatic build_frame();
        logic [7:0] hi;
        logic [7:0] lo;
`ifdef USB_TX_CHECKSUM_EN
        logic [7:0] sum;
        sum = fc;
`endif
        pend.push_back('{USB_SYNC1, 1'b0});
        pend.push_back('{fc, 1'b0});
        for (int i = 0; i < FL; i++) begin
            hi = {4'h0, mq[i][11:8]};
            lo = mq[i][7:0];
            pend.push_back('{hi, 1'b0});
            pend.push_back('{lo, 1'b1});
`ifdef USB_TX_CHECKSUM_EN
            sum = sum + hi + lo;
`endif
        end
`ifdef USB_TX_CHECKSUM_EN
        pend.push_back('{sum, 1'b0});
`endif
        cur      = USB_SYNC0;
        cur_p    = 1'b0;
        in_frame = 1'b1;
    endtask

    // One clock: drive, check ready, advance model on the edge, check outputs
    task automatic step(input bit txe_n, input bit wr_n, input bit vld,
                        input logic [11:0] d);
        bit         cons;
        bit         pop;
        bit         rdy;
        logic [7:0] seen;
        ent_t       e;
        txe_n_i = txe_n;
        wr_n_i  = wr_n;
        valid_i = vld;
        data_i  = d;
        cons = !txe_n && !wr_n;
        pop  = cons && cur_p;
        rdy  = (mq.size() < DEPTH) || pop;
        #1;
        chk("ready_o", ready_o, rdy);
        seen = wdata_o;
        @(posedge clk_i);
        if (vld && !rdy) m_ovf = 1'b1;
        if (cons) begin
            if (logging) got.push_back(seen);
            if (pop) void'(mq.pop_front());
            if (pend.size() > 0) begin
                e     = pend.pop_front();
                cur   = e.b;
                cur_p = e.p;
            end else if (in_frame) begin
                in_frame = 1'b0;
                fc       = fc + 8'd1;
                cur      = USB_FILL;
                cur_p    = 1'b0;
            end else if (mq.size() >= FL) begin
                build_frame();
            end
        end
        if (vld && rdy) mq.push_back(d);
        #1;
        chk("wdata_o", wdata_o, cur);
        chk("frame_cnt_o", frame_cnt_o, fc);
        chk("overflow_o", overflow_o, m_ovf);
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        #1;
        model_reset();
        chk("rst_wdata", wdata_o, USB_FILL);
        chk("rst_frame_cnt", frame_cnt_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_overflow", overflow_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Locate the first header in the log and check its leading bytes
    task automatic check_head(input string nm, input logic [7:0] cnt);
        k = -1;
        for (int i = 0; i < got.size(); i++) begin
            if (k < 0 && got[i] == USB_SYNC0) k = i;
        end
        if (k < 0 || k + 3 > got.size()) begin
            chk({nm, "_hdr_found"}, 0, 1);
        end else begin
            chk({nm, "_sync0"}, got[k], 8'hA5);
            chk({nm, "_sync1"}, got[k+1], 8'h5A);
            chk({nm, "_cnt"}, got[k+2], cnt);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        logging = 1'b0;
        model_reset();

        // Test 1: idle stream is filler whatever the handshake does
        tbl[0] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 8'h00, 8'h00, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].txe_n, tbl[i].wr_n, 1'b0, 12'h000);
            chk("tbl_wdata", wdata_o, tbl[i].wd);
            chk("tbl_frame_cnt", frame_cnt_o, tbl[i].fcx);
            chk("tbl_ready", ready_o, tbl[i].rdy);
        end

        // Test 2: one frame of 0..63
        got.delete();
        logging = 1'b1;
        for (int i = 0; i < FL; i++) step(1'b0, 1'b0, 1'b1, 12'(i));
        for (int i = 0; i < FBYTES + 20; i++) step(1'b0, 1'b0, 1'b0, 12'h0);
        logging = 1'b0;
        hdr = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        check_head("t2", 8'h00);
        if (k < 0 || k + FBYTES + 1 > got.size()) begin
            chk("t2_frame_len", got.size(), k + FBYTES + 1);
        end else begin
            for (int j = 3; j < 7; j++) chk("t2_lead", got[k+j], hdr[j]);
            chk("t2_last_hi", got[k+129], 8'h00);
            chk("t2_last_lo", got[k+130], 8'h3F);
`ifdef USB_TX_CHECKSUM_EN
            chk("t2_csum", got[k+131], 8'hE0);
`endif
            chk("t2_fill", got[k+FBYTES], 8'h00);
        end
        chk("t2_frame_cnt", frame_cnt_o, 1);

        // Test 3: TXE# and WR# stalls across three random frames
        fc0  = fc;
        sent = 0;
        for (int i = 0; i < 3000 && fc != 8'(fc0 + 3); i++) begin
            automatic bit th = ((i % 61) >= 30) && ((i % 61) < 35);
            automatic bit wh = ($urandom_range(0, 9) == 0);
            automatic bit v  = (mq.size() < 100) && (sent < 3 * FL);
            step(th, wh, v, v ? 12'($urandom) : 12'h0);
            if (v) sent++;
        end
        chk("t3_frame_cnt", frame_cnt_o, 8'(fc0 + 3));

        // Test 4: overflow with TXE# held high
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, 12'(i));
        chk("t4_full_ready", ready_o, 0);
        step(1'b1, 1'b0, 1'b1, 12'hFFF);
        chk("t4_overflow", overflow_o, 1);
        for (int i = 0; i < 2 * FBYTES + 10; i++) step(1'b0, 1'b0, 1'b0, 12'h0);
        chk("t4_frame_cnt", frame_cnt_o, 2);
        chk("t4_drained", ready_o, 1);

        // Test 5: reset in DATA, FIFO full with push/pop overlap
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b1, 12'(i + 300));
        for (int i = 0; i < 200 && !(in_frame && pend.size() < 100); i++) begin
            step(1'b0, 1'b0, 1'b1, 12'($urandom));
        end
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 12'h0);
        got.delete();
        logging = 1'b1;
        for (int i = 0; i < FL; i++) step(1'b0, 1'b0, 1'b1, 12'(i * 7));
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 12'h0);
        logging = 1'b0;
        check_head("t5", 8'h00);

        // Test 6: 256 frames, frame counter wraps to 0
        do_reset();
        frames = 0;
        for (int i = 0; i < 40000 && frames < 256; i++) begin
            automatic bit v = (mq.size() < 100);
            prev_fc = fc;
            step(1'b0, 1'b0, v, 12'($urandom));
            if (fc != prev_fc) frames++;
        end
        chk("t6_wrap", frame_cnt_o, 0);
        chk("t6_overflow", overflow_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
